// File: rtl/tilemem_writer.sv
// ============================================================================
// Module   : tilemem_writer
// Purpose  : Write-port driver for the character tile RAM scanned by the video
//            tile reader. Takes a byte stream, keeps a text cursor, and writes
//            character codes at addr = row*80 + col. Handles CR/LF/BS/FF,
//            wraps lines and the screen, and blanks each new line before use.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   ZOOM          log2 tile scale; COLS = 80>>ZOOM, ROWS = 60>>ZOOM (ZOOM<=5)
//   BLANK         char code written when blanking
// Ports
//   clk           in   system clock, posedge
//   rstn          in   synchronous active-low reset
//   char_i        in   incoming char code (`FONT_WIDTH bits)
//   char_valid_i  in   char_i valid
//   ready_o       out  block can accept (transfer on char_valid_i && ready_o)
//   write_en_o    out  RAM write strobe, one cycle per word
//   waddr_o       out  RAM word address, row*80 + col
//   wdata_o       out  RAM write data
//   col_o         out  cursor column
//   row_o         out  cursor row
// Build option
//   CLEAR_ON_RESET_EN  when defined, the whole screen is blanked after reset
//                      before the first ready_o=1.
// ============================================================================
`default_nettype none

`ifndef FONT_WIDTH
`define FONT_WIDTH 8
`endif

module tilemem_writer #(
  parameter int ZOOM  = 0,
  parameter int BLANK = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [`FONT_WIDTH-1:0] char_i,
  input  logic                   char_valid_i,
  output logic                   ready_o,
  output logic                   write_en_o,
  output logic [12:0]            waddr_o,
  output logic [`FONT_WIDTH-1:0] wdata_o,
  output logic [6:0]             col_o,
  output logic [5:0]             row_o
);

  localparam int FW   = `FONT_WIDTH;
  localparam int COLS = 80 >> ZOOM;
  localparam int ROWS = 60 >> ZOOM;

  localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
  localparam logic [6:0]    COL_END  = 7'(COLS);
  localparam logic [5:0]    ROW_LAST = 6'(ROWS - 1);
  localparam logic [5:0]    ROW_END  = 6'(ROWS);
  localparam logic [FW-1:0] BLANK_CH = FW'(BLANK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUT     = 2'd1,
    CLRLINE = 2'd2,
    CLRSCR  = 2'd3
  } state_t;

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLRSCR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t          state;
  logic [6:0]      col;
  logic [5:0]      row;
  logic [6:0]      clr_col;   // next column to blank
  logic [5:0]      clr_row;   // next row to blank (CLRSCR only)
  logic            wrap;      // the printable in PUT ended a line
  logic            ready;
  logic            write_en;
  logic [12:0]     waddr;
  logic [FW-1:0]   wdata;

  // row*80 as a shift-add; fits 13 bits for any row below 64
  function automatic logic [12:0] row_base(input logic [5:0] r);
    row_base = ({7'd0, r} << 6) + ({7'd0, r} << 4);
  endfunction

  logic            accept;
  logic            is_print;
  logic            is_bs;
  logic            is_cr;
  logic            is_lf;
  logic            is_ff;
  logic [5:0]      next_row;
  logic [12:0]     cur_addr;

  always_comb begin
    accept   = char_valid_i && ready;
    is_print = (char_i >= FW'(8'h20)) && (char_i != FW'(8'h7F));
    is_bs    = (char_i == FW'(8'h08));
    is_cr    = (char_i == FW'(8'h0D));
    is_lf    = (char_i == FW'(8'h0A));
    is_ff    = (char_i == FW'(8'h0C));
    next_row = (row == ROW_LAST) ? 6'd0 : row + 6'd1;
    cur_addr = row_base(row) + {6'd0, col};
  end

  // Every write is registered in the same edge that decides it, so the
  // first word of a clear appears in the cycle right after the command and
  // ready_o is low for exactly the cycles that carry writes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= RESET_STATE;
      col      <= 7'd0;
      row      <= 6'd0;
      clr_col  <= 7'd0;
      clr_row  <= 6'd0;
      wrap     <= 1'b0;
      ready    <= 1'b0;
      write_en <= 1'b0;
      waddr    <= 13'd0;
      wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          write_en <= 1'b0;
          ready    <= 1'b1;
          if (accept) begin
            if (is_print) begin
              write_en <= 1'b1;
              waddr    <= cur_addr;
              wdata    <= char_i;
              ready    <= 1'b0;
              state    <= PUT;
              // cursor moves now; PUT only finishes the wrap handling
              if (col == COL_LAST) begin
                col  <= 7'd0;
                row  <= next_row;
                wrap <= 1'b1;
              end else begin
                col  <= col + 7'd1;
                wrap <= 1'b0;
              end
            end else if (is_bs) begin
              if (col != 7'd0) begin
                col      <= col - 7'd1;
                write_en <= 1'b1;
                waddr    <= cur_addr - 13'd1;
                wdata    <= BLANK_CH;
                ready    <= 1'b0;
                wrap     <= 1'b0;
                state    <= PUT;
              end
            end else if (is_cr) begin
              col <= 7'd0;
            end else if (is_lf) begin
              col      <= 7'd0;
              row      <= next_row;
              write_en <= 1'b1;
              waddr    <= row_base(next_row);
              wdata    <= BLANK_CH;
              clr_col  <= 7'd1;
              ready    <= 1'b0;
              state    <= CLRLINE;
            end else if (is_ff) begin
              col      <= 7'd0;
              row      <= 6'd0;
              write_en <= 1'b1;
              waddr    <= 13'd0;
              wdata    <= BLANK_CH;
              clr_col  <= 7'd1;
              clr_row  <= 6'd0;
              ready    <= 1'b0;
              state    <= CLRSCR;
            end
            // remaining control codes are consumed with no effect
          end
        end

        PUT: begin
          if (wrap) begin
            // row already advanced; start blanking it immediately
            wrap     <= 1'b0;
            write_en <= 1'b1;
            waddr    <= row_base(row);
            wdata    <= BLANK_CH;
            clr_col  <= 7'd1;
            state    <= CLRLINE;
          end else begin
            write_en <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end
        end

        CLRLINE: begin
          if (clr_col == COL_END) begin
            write_en <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            write_en <= 1'b1;
            waddr    <= row_base(row) + {6'd0, clr_col};
            wdata    <= BLANK_CH;
            clr_col  <= clr_col + 7'd1;
          end
        end

        CLRSCR: begin
          if (clr_row == ROW_END) begin
            write_en <= 1'b0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            write_en <= 1'b1;
            waddr    <= row_base(clr_row) + {6'd0, clr_col};
            wdata    <= BLANK_CH;
            if (clr_col == COL_LAST) begin
              clr_col <= 7'd0;
              clr_row <= clr_row + 6'd1;
            end else begin
              clr_col <= clr_col + 7'd1;
            end
          end
        end

        default: begin
          write_en <= 1'b0;
          ready    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign ready_o    = ready;
  assign write_en_o = write_en;
  assign waddr_o    = waddr;
  assign wdata_o    = wdata;
  assign col_o      = col;
  assign row_o      = row;

endmodule

`default_nettype wire

// File: tb/tb_tilemem_writer.sv
// ============================================================================
// Module   : tb_tilemem_writer
// Purpose  : Self-checking bench for tilemem_writer; one ZOOM=0 and one
//            ZOOM=1 instance, a shadow of every RAM write, and a screen-level
//            reference model of cursor, RAM contents and busy time.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tilemem_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  ch0 = 8'd0, ch1 = 8'd0;
  logic        vld0 = 1'b0, vld1 = 1'b0;
  logic        rdy0, rdy1, we0, we1;
  logic [12:0] wa0, wa1;
  logic [7:0]  wd0, wd1;
  logic [6:0]  col0, col1;
  logic [5:0]  row0, row1;

  always #5 clk = ~clk;

  tilemem_writer #(.ZOOM(0), .BLANK(32)) dut0 (
    .clk(clk), .rstn(rstn), .char_i(ch0), .char_valid_i(vld0),
    .ready_o(rdy0), .write_en_o(we0), .waddr_o(wa0), .wdata_o(wd0),
    .col_o(col0), .row_o(row0)
  );

  tilemem_writer #(.ZOOM(1), .BLANK(32)) dut1 (
    .clk(clk), .rstn(rstn), .char_i(ch1), .char_valid_i(vld1),
    .ready_o(rdy1), .write_en_o(we1), .waddr_o(wa1), .wdata_o(wd1),
    .col_o(col1), .row_o(row1)
  );

  int total = 0;
  int bad   = 0;

  // shadow of what each DUT wrote, and what the model says the screen holds
  logic [7:0] sram [2][8192];
  logic [7:0] mram [2][8192];
  int         mcol [2];
  int         mrow [2];

  // write monitor bookkeeping
  int         nwr [2];
  int         la  [2];
  int         ld  [2];
  int         fa  [2];
  int         mn  [2];
  int         mx  [2];

  int         g_busy;
  int         g_nw;

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      sram[0][wa0] = wd0;
      nwr[0]++;
      la[0] = int'(wa0); ld[0] = int'(wd0);
      if (fa[0] < 0) fa[0] = int'(wa0);
      if (int'(wa0) < mn[0]) mn[0] = int'(wa0);
      if (int'(wa0) > mx[0]) mx[0] = int'(wa0);
    end
    if (we1 === 1'b1) begin
      sram[1][wa1] = wd1;
      nwr[1]++;
      la[1] = int'(wa1); ld[1] = int'(wd1);
      if (fa[1] < 0) fa[1] = int'(wa1);
      if (int'(wa1) < mn[1]) mn[1] = int'(wa1);
      if (int'(wa1) > mx[1]) mx[1] = int'(wa1);
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", nm, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic rdy(input int z);
    return (z == 0) ? rdy0 : rdy1;
  endfunction

  function automatic int colv(input int z);
    return (z == 0) ? int'(col0) : int'(col1);
  endfunction

  function automatic int rowv(input int z);
    return (z == 0) ? int'(row0) : int'(row1);
  endfunction

  task automatic drive(input int z, input logic [7:0] c, input logic v);
    if (z == 0) begin ch0 = c; vld0 = v; end
    else begin ch1 = c; vld1 = v; end
  endtask

  // Screen-level model: what a terminal of COLS x ROWS does with one byte.
  task automatic model_apply(input int z, input logic [7:0] c,
                             output int busy, output int nw,
                             output int laddr, output int ldata);
    int cols, rows;
    bit nl;
    cols = 80 >> z; rows = 60 >> z;
    busy = 0; nw = 0; laddr = -1; ldata = -1; nl = 0;
    if (c >= 8'h20 && c != 8'h7F) begin
      laddr = mrow[z] * 80 + mcol[z]; ldata = int'(c);
      mram[z][laddr] = c; busy = 1; nw = 1;
      mcol[z]++;
      if (mcol[z] == cols) begin mcol[z] = 0; nl = 1; end
    end else if (c == 8'h08) begin
      if (mcol[z] > 0) begin
        mcol[z]--;
        laddr = mrow[z] * 80 + mcol[z]; ldata = 32;
        mram[z][laddr] = 8'd32; busy = 1; nw = 1;
      end
    end else if (c == 8'h0D) begin
      mcol[z] = 0;
    end else if (c == 8'h0A) begin
      mcol[z] = 0; nl = 1;
    end else if (c == 8'h0C) begin
      mcol[z] = 0; mrow[z] = 0;
      for (int y = 0; y < rows; y++)
        for (int x = 0; x < cols; x++) begin
          laddr = y * 80 + x; ldata = 32;
          mram[z][laddr] = 8'd32;
        end
      busy = rows * cols; nw = rows * cols;
    end
    if (nl) begin
      mrow[z] = (mrow[z] + 1) % rows;
      for (int x = 0; x < cols; x++) begin
        laddr = mrow[z] * 80 + x; ldata = 32;
        mram[z][laddr] = 8'd32;
      end
      busy += cols; nw += cols;
    end
  endtask

  // Present a byte, hold it until accepted, then count busy cycles.
  task automatic send(input int z, input logic [7:0] c, output int busy);
    int guard;
    @(negedge clk);
    drive(z, c, 1'b1);
    guard = 0;
    while (!rdy(z) && guard < 20000) begin @(negedge clk); guard++; end
    if (guard >= 20000) check("accept_timeout", 1, 0);
    @(negedge clk);
    drive(z, 8'd0, 1'b0);
    busy = 0;
    while (!rdy(z) && busy < 20000) begin busy++; @(negedge clk); end
    if (busy >= 20000) check("busy_timeout", 1, 0);
    #1;
  endtask

  task automatic ram_check(input int z, input string nm);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 4800; i++)
      if (sram[z][i] !== mram[z][i]) diffs++;
    check(nm, diffs, 0);
  endtask

  task automatic step(input int z, input logic [7:0] c);
    int eb, en, ela, eld, b, base;
    model_apply(z, c, eb, en, ela, eld);
    base = nwr[z]; fa[z] = -1; mn[z] = 1 << 20; mx[z] = -1;
    send(z, c, b);
    g_busy = b; g_nw = nwr[z] - base;
    check("busy_cycles", b, eb);
    check("write_count", g_nw, en);
    check("cursor_col", colv(z), mcol[z]);
    check("cursor_row", rowv(z), mrow[z]);
    if (en > 0) begin
      check("last_waddr", la[z], ela);
      check("last_wdata", ld[z], eld);
    end
    ram_check(z, "ram_contents");
  endtask

  typedef struct {
    logic [7:0] ch;
    int col; int row; int busy; int nw; int la; int ld;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int base;
    logic [7:0] c;
    int r, nff;

    tbl[0] = '{8'h42, 2, 0,  1,  1,   1, 8'h42};  // 'B'
    tbl[1] = '{8'h08, 1, 0,  1,  1,   1, 8'h20};  // BS blanks col 1
    tbl[2] = '{8'h0D, 0, 0,  0,  0,  -1, -1};     // CR
    tbl[3] = '{8'h08, 0, 0,  0,  0,  -1, -1};     // BS at col 0: no-op
    tbl[4] = '{8'h01, 0, 0,  0,  0,  -1, -1};     // ignored control
    tbl[5] = '{8'hC8, 1, 0,  1,  1,   0, 8'hC8};  // high printable
    tbl[6] = '{8'h0A, 0, 1, 80, 80, 159, 8'h20};  // LF blanks row 1
    tbl[7] = '{8'h78, 1, 1,  1,  1,  80, 8'h78};  // 'x'
    tbl[8] = '{8'h08, 0, 1,  1,  1,  80, 8'h20};  // BS -> blank at 80
    tbl[9] = '{8'h1B, 0, 1,  0,  0,  -1, -1};     // ESC ignored

    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8192; i++) begin sram[z][i] = 8'd0; mram[z][i] = 8'd0; end
      mcol[z] = 0; mrow[z] = 0; nwr[z] = 0; fa[z] = -1; mn[z] = 0; mx[z] = 0;
      la[z] = 0; ld[z] = 0;
    end

    // ---------------- reset ----------------
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(rdy0), 0);
    check("rst_write_en", int'(we0), 0);
    check("rst_waddr", int'(wa0), 0);
    check("rst_wdata", int'(wd0), 0);
    check("rst_col", int'(col0), 0);
    check("rst_row", int'(row0), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_release0", int'(rdy0), 1);
    check("ready_after_release1", int'(rdy1), 1);

    // ---------------- 'A' latency ----------------
    ch0 = 8'h41; vld0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0;
    check("A_write_en", int'(we0), 1);
    check("A_waddr", int'(wa0), 0);
    check("A_wdata", int'(wd0), 8'h41);
    check("A_ready_low", int'(rdy0), 0);
    check("A_col", int'(col0), 1);
    @(negedge clk);
    check("A_ready_back", int'(rdy0), 1);
    check("A_write_done", int'(we0), 0);
    begin
      int b, n, a, d;
      model_apply(0, 8'h41, b, n, a, d);
    end
    #1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].ch);
      check("tbl_col", int'(col0), tbl[i].col);
      check("tbl_row", int'(row0), tbl[i].row);
      check("tbl_busy", g_busy, tbl[i].busy);
      check("tbl_nw", g_nw, tbl[i].nw);
      if (tbl[i].nw > 0) begin
        check("tbl_waddr", la[0], tbl[i].la);
        check("tbl_wdata", ld[0], tbl[i].ld);
      end
    end

    // ---------------- LF at row 2 col 5 ----------------
    step(0, 8'h0A);
    for (int i = 0; i < 5; i++) step(0, 8'h61 + 8'(i));
    check("pre_lf_col", int'(col0), 5);
    check("pre_lf_row", int'(row0), 2);
    step(0, 8'h0A);
    check("lf_row", int'(row0), 3);
    check("lf_col", int'(col0), 0);
    check("lf_busy", g_busy, 80);
    check("lf_min_addr", mn[0], 240);
    check("lf_max_addr", mx[0], 319);

    // ---------------- FF at row 7 ----------------
    repeat (4) step(0, 8'h0A);
    check("pre_ff_row", int'(row0), 7);
    step(0, 8'h0C);
    check("ff_writes", g_nw, 4800);
    check("ff_busy", g_busy, 4800);
    check("ff_min_addr", mn[0], 0);
    check("ff_max_addr", mx[0], 4799);
    check("ff_col", int'(col0), 0);
    check("ff_row", int'(row0), 0);

    // ---------------- ZOOM=1 wrap at screen end ----------------
    repeat (29) step(1, 8'h0A);
    repeat (39) step(1, 8'h6B);
    check("z1_pre_row", int'(row1), 29);
    check("z1_pre_col", int'(col1), 39);
    step(1, 8'h5A);
    check("z1_first_addr", fa[1], 2359);
    check("z1_writes", g_nw, 41);
    check("z1_max_addr", mx[1], 2359);
    check("z1_min_addr", mn[1], 0);
    check("z1_last_addr", la[1], 39);
    check("z1_col", int'(col1), 0);
    check("z1_row", int'(row1), 0);

    // ---------------- reset in the middle of a screen clear ----------------
    @(negedge clk);
    ch0 = 8'h0C; vld0 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0;
    repeat (100) @(negedge clk);
    check("midclr_busy", int'(rdy0), 0);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_write_en", int'(we0), 0);
    check("abort_ready", int'(rdy0), 0);
    check("abort_col", int'(col0), 0);
    check("abort_row", int'(row0), 0);
    check("abort_waddr", int'(wa0), 0);
    #1 base = nwr[0];
    repeat (3) @(negedge clk);
    #1 check("abort_no_writes", nwr[0] - base, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rerelease_ready", int'(rdy0), 1);
    #1;
    for (int z = 0; z < 2; z++) begin mcol[z] = 0; mrow[z] = 0; end
    step(0, 8'h0C);

    // ---------------- valid held while busy: accepted once ----------------
    @(negedge clk);
    ch0 = 8'h0A; vld0 = 1'b1;
    #1 base = nwr[0];
    @(negedge clk);
    ch0 = 8'h71;
    begin
      int guard, b, n, a, d;
      guard = 0;
      while (!rdy0 && guard < 1000) begin @(negedge clk); guard++; end
      if (guard >= 1000) check("held_timeout", 1, 0);
      @(negedge clk);
      vld0 = 1'b0;
      guard = 0;
      while (!rdy0 && guard < 1000) begin @(negedge clk); guard++; end
      repeat (3) @(negedge clk);
      #1;
      model_apply(0, 8'h0A, b, n, a, d);
      model_apply(0, 8'h71, b, n, a, d);
    end
    check("held_writes", nwr[0] - base, 81);
    check("held_col", int'(col0), 1);
    check("held_row", int'(row0), 1);
    ram_check(0, "held_ram");

    // ---------------- randomized stream vs model ----------------
    nff = 0;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if ($urandom_range(0, 1) == 1) c = 8'($urandom_range(32, 126));
        else c = 8'($urandom_range(128, 255));
      end else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 93) c = 8'h08;
      else if (r == 99 && nff < 2) begin c = 8'h0C; nff++; end
      else begin
        c = 8'($urandom_range(0, 31));
        while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D)
          c = 8'($urandom_range(0, 31));
      end
      step(0, c);
    end
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) c = 8'($urandom_range(32, 126));
      else if (r == 7) c = 8'h0A;
      else c = 8'h08;
      step(1, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
